// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler: phase encoding,
// lamp patterns, default durations and small decode helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_NS_GREEN  = 3'd1,
        PH_NS_YELLOW = 3'd2,
        PH_AR1       = 3'd3,
        PH_EW_GREEN  = 3'd4,
        PH_EW_YELLOW = 3'd5,
        PH_AR2       = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_CNT_W     = 32'sd8;
    localparam int DEF_GREEN_T   = 32'sd60;
    localparam int DEF_YELLOW_T  = 32'sd5;
    localparam int DEF_ALLRED_T  = 32'sd2;
    localparam int DEF_MIN_GREEN = 32'sd10;

    // Fixed rotation; an illegal code falls back to the power-up state.
    function automatic phase_e next_phase(input phase_e cur);
        case (cur)
            PH_IDLE:      next_phase = PH_NS_GREEN;
            PH_NS_GREEN:  next_phase = PH_NS_YELLOW;
            PH_NS_YELLOW: next_phase = PH_AR1;
            PH_AR1:       next_phase = PH_EW_GREEN;
            PH_EW_GREEN:  next_phase = PH_EW_YELLOW;
            PH_EW_YELLOW: next_phase = PH_AR2;
            PH_AR2:       next_phase = PH_NS_GREEN;
            default:      next_phase = PH_IDLE;
        endcase
    endfunction

    function automatic logic is_green(input phase_e p);
        is_green = (p == PH_NS_GREEN) || (p == PH_EW_GREEN);
    endfunction

    function automatic logic is_yellow(input phase_e p);
        is_yellow = (p == PH_NS_YELLOW) || (p == PH_EW_YELLOW);
    endfunction

    // Returns {ns_lamps, ew_lamps}; anything not explicitly green/yellow is all-red.
    function automatic logic [5:0] lamps_of(input phase_e p);
        case (p)
            PH_NS_GREEN:  lamps_of = {LAMP_GRN, LAMP_RED};
            PH_NS_YELLOW: lamps_of = {LAMP_YEL, LAMP_RED};
            PH_EW_GREEN:  lamps_of = {LAMP_RED, LAMP_GRN};
            PH_EW_YELLOW: lamps_of = {LAMP_RED, LAMP_YEL};
            default:      lamps_of = {LAMP_RED, LAMP_RED};
        endcase
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Control/status bundle between the scheduler and its environment.
interface intersection_phase_scheduler_if #(
    parameter int CNT_W = 32'sd8
);
    logic             hold;
    logic             ped_req;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic [CNT_W-1:0] countdown;
    logic [2:0]       phase;

    modport master (
        output hold, ped_req,
        input  ns_light, ew_light, countdown, phase
    );

    modport slave (
        input  hold, ped_req,
        output ns_light, ew_light, countdown, phase
    );
endinterface

// File: rtl/intersection_phase_scheduler_chk.sv
// Safety properties on the lamp outputs of the intersection scheduler.
module intersection_phase_scheduler_chk
    import traffic_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input logic [2:0] ns_light,
    input logic [2:0] ew_light
);
    a_one_head_red: assert property (@(posedge clk) disable iff (rst)
        (ns_light == LAMP_RED) || (ew_light == LAMP_RED));

    a_ns_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(ns_light));

    a_ew_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(ew_light));
endmodule

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Loadable down-counter for phase durations; saturates at zero.
module phase_timer #(
    parameter int CNT_W = 32'sd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    logic [CNT_W-1:0] count_r;

    // Load has priority over decrement; nothing moves while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (load) begin
                count_r <= load_val;
            end else if (count_r != {CNT_W{1'b0}}) begin
                count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {CNT_W{1'b0}});
endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-head intersection sequencer: phase FSM, pedestrian shorten latch and
// registered lamp decode. Durations are counted by phase_timer.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GREEN_T   = DEF_GREEN_T,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int MIN_GREEN = DEF_MIN_GREEN
) (
    input  logic                           clk,
    input  logic                           rst,
    intersection_phase_scheduler_if.slave  bus
);
    localparam int CNT_MAX = 2 ** CNT_W;

    if (GREEN_T < 32'sd1 || GREEN_T > CNT_MAX) begin : g_bad_green
        $error("GREEN_T does not fit in CNT_W");
    end
    if (YELLOW_T < 32'sd1 || YELLOW_T > CNT_MAX) begin : g_bad_yellow
        $error("YELLOW_T does not fit in CNT_W");
    end
    if (ALLRED_T < 32'sd1 || ALLRED_T > CNT_MAX) begin : g_bad_allred
        $error("ALLRED_T does not fit in CNT_W");
    end
    if (MIN_GREEN < 32'sd1 || MIN_GREEN > GREEN_T) begin : g_bad_min
        $error("MIN_GREEN must be in 1..GREEN_T");
    end

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 32'sd1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 32'sd1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 32'sd1);
    localparam logic [CNT_W-1:0] MIN_LD    = CNT_W'(MIN_GREEN - 32'sd1);

    phase_e           state_r;
    phase_e           next_state_s;
    logic             ped_pending_r;
    logic             ped_pending_next_s;
    logic             eff_req_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic [CNT_W-1:0] count_s;
    logic             zero_s;
    logic [2:0]       ns_light_r;
    logic [2:0]       ew_light_r;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .en       (~bus.hold),
        .count    (count_s),
        .zero     (zero_s)
    );

    // Next-state, counter reload and request bookkeeping. A request arriving
    // on this edge counts as pending already; a phase change takes priority
    // over shortening, so a request seen at the end of a green carries over.
    always_comb begin
        eff_req_s          = ped_pending_r | bus.ped_req;
        next_state_s       = state_r;
        ped_pending_next_s = eff_req_s;
        load_s             = 1'b0;
        load_val_s         = GREEN_LD;
        if (bus.hold) begin
            ped_pending_next_s = eff_req_s;
        end else if (zero_s) begin
            next_state_s = next_phase(state_r);
            load_s       = 1'b1;
            if (is_green(next_state_s)) begin
                load_val_s         = eff_req_s ? MIN_LD : GREEN_LD;
                ped_pending_next_s = 1'b0;
            end else if (is_yellow(next_state_s)) begin
                load_val_s = YELLOW_LD;
            end else begin
                load_val_s = ALLRED_LD;
            end
        end else if (is_green(state_r) && eff_req_s) begin
            ped_pending_next_s = 1'b0;
            if (count_s > MIN_LD) begin
                load_s     = 1'b1;
                load_val_s = MIN_LD;
            end else begin
                load_s     = 1'b0;
            end
        end else begin
            ped_pending_next_s = eff_req_s;
        end
    end

    // State, request latch and lamps all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= PH_IDLE;
            ped_pending_r <= 1'b0;
            ns_light_r    <= LAMP_RED;
            ew_light_r    <= LAMP_RED;
        end else begin
            state_r                  <= next_state_s;
            ped_pending_r            <= ped_pending_next_s;
            {ns_light_r, ew_light_r} <= lamps_of(next_state_s);
        end
    end

    assign bus.ns_light  = ns_light_r;
    assign bus.ew_light  = ew_light_r;
    assign bus.countdown = count_s;
    assign bus.phase     = state_r;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: reset/sequence vector table,
// hand-written pedestrian/hold/reset sequences, and a randomized run
// compared every cycle against a phase/elapsed-time model.
module tb_intersection_phase_scheduler;
    import traffic_pkg::*;

    localparam int CNT_W = 8;
    localparam int MIN_G = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k = 0;

    intersection_phase_scheduler_if #(.CNT_W(CNT_W)) bus ();

    intersection_phase_scheduler #(
        .CNT_W(CNT_W), .GREEN_T(60), .YELLOW_T(5), .ALLRED_T(2), .MIN_GREEN(MIN_G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    intersection_phase_scheduler_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .ns_light (bus.ns_light),
        .ew_light (bus.ew_light)
    );

    always #5 clk = ~clk;

    // Reference model: phase index, cycles elapsed in phase, phase length.
    typedef struct {
        int p;
        int e;
        int l;
        bit pend;
    } mstate_t;

    localparam mstate_t M_RST = '{p: 0, e: 0, l: 1, pend: 1'b0};
    mstate_t ms = M_RST;

    function automatic int dur_of(int p);
        case (p)
            1, 4:    return 60;
            2, 5:    return 5;
            3, 6:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit green_ph(int p);
        return (p == 1) || (p == 4);
    endfunction

    function automatic mstate_t model_next(mstate_t s, bit h, bit req);
        mstate_t n = s;
        bit eff = s.pend | req;
        int rem = s.l - 1 - s.e;
        if (h) begin
            n.pend = eff;
            return n;
        end
        if (rem == 0) begin
            n.p = (s.p == 0 || s.p == 6) ? 1 : s.p + 1;
            n.e = 0;
            n.l = dur_of(n.p);
            if (green_ph(n.p)) begin
                if (eff) n.l = MIN_G;
                n.pend = 1'b0;
            end else begin
                n.pend = eff;
            end
        end else begin
            n.e = s.e + 1;
            n.pend = eff;
            if (green_ph(s.p) && eff) begin
                n.pend = 1'b0;
                if (rem > MIN_G - 1) n.l = n.e + MIN_G;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] ns_exp(int p);
        case (p)
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_exp(int p);
        case (p)
            4:       return 3'b001;
            5:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d required %0d", name, $time, got, exp);
        end
    endtask

    // Advance the model on every active edge (or immediately on reset).
    always @(posedge clk or posedge rst) begin
        if (rst) ms <= M_RST;
        else     ms <= model_next(ms, bus.hold, bus.ped_req);
    end

    // Compare DUT against the model mid-cycle, plus the one-red invariant.
    always @(negedge clk) begin
        check("model_phase", {29'd0, bus.phase}, ms.p);
        check("model_countdown", {24'd0, bus.countdown}, ms.l - 1 - ms.e);
        check("model_ns", {29'd0, bus.ns_light}, {29'd0, ns_exp(ms.p)});
        check("model_ew", {29'd0, bus.ew_light}, {29'd0, ew_exp(ms.p)});
        check("one_red", {31'd0, (bus.ns_light == LAMP_RED) || (bus.ew_light == LAMP_RED)}, 32'd1);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic expect_now(input string tag, input int ph, input int cd,
                              input logic [2:0] ns, input logic [2:0] ew);
        check({tag, "_phase"}, {29'd0, bus.phase}, ph);
        check({tag, "_cd"}, {24'd0, bus.countdown}, cd);
        check({tag, "_ns"}, {29'd0, bus.ns_light}, {29'd0, ns});
        check({tag, "_ew"}, {29'd0, bus.ew_light}, {29'd0, ew});
    endtask

    typedef struct {
        int         k;
        bit         hold;
        bit         ped;
        int         ph;
        int         cd;
        logic [2:0] ns;
        logic [2:0] ew;
    } vec_t;

    vec_t vecs[$];
    int   hold_left;

    initial begin
        bus.hold    = 1'b0;
        bus.ped_req = 1'b0;

        // Test 1: one full rotation after reset release, k = edges since release.
        vecs.push_back('{0,   0, 0, 0, 0,  3'b100, 3'b100});
        vecs.push_back('{1,   0, 0, 1, 59, 3'b001, 3'b100});
        vecs.push_back('{60,  0, 0, 1, 0,  3'b001, 3'b100});
        vecs.push_back('{61,  0, 0, 2, 4,  3'b010, 3'b100});
        vecs.push_back('{65,  0, 0, 2, 0,  3'b010, 3'b100});
        vecs.push_back('{66,  0, 0, 3, 1,  3'b100, 3'b100});
        vecs.push_back('{67,  0, 0, 3, 0,  3'b100, 3'b100});
        vecs.push_back('{68,  0, 0, 4, 59, 3'b100, 3'b001});
        vecs.push_back('{127, 0, 0, 4, 0,  3'b100, 3'b001});
        vecs.push_back('{128, 0, 0, 5, 4,  3'b100, 3'b010});
        vecs.push_back('{133, 0, 0, 6, 1,  3'b100, 3'b100});
        vecs.push_back('{134, 0, 0, 6, 0,  3'b100, 3'b100});
        vecs.push_back('{135, 0, 0, 1, 59, 3'b001, 3'b100});

        repeat (2) @(posedge clk);
        expect_now("reset", 0, 0, 3'b100, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        #1;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) begin
                bus.hold    = vecs[i].hold;
                bus.ped_req = vecs[i].ped;
                step(1);
            end
            expect_now($sformatf("vec%0d", i), vecs[i].ph, vecs[i].cd, vecs[i].ns, vecs[i].ew);
        end

        // Test 2: request at NS_GREEN countdown 40 shortens to 10 cycles.
        step(19);
        expect_now("t2_pre", 1, 40, 3'b001, 3'b100);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        expect_now("t2_short", 1, 9, 3'b001, 3'b100);
        step(9);
        expect_now("t2_last", 1, 0, 3'b001, 3'b100);
        step(1);
        expect_now("t2_yel", 2, 4, 3'b010, 3'b100);

        // Test 3: request during yellow waits for the EW green.
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        expect_now("t3_yel", 2, 3, 3'b010, 3'b100);
        step(4);
        expect_now("t3_ar1", 3, 1, 3'b100, 3'b100);
        step(2);
        expect_now("t3_ewg", 4, 9, 3'b100, 3'b001);
        step(9);
        expect_now("t3_ewg_last", 4, 0, 3'b100, 3'b001);
        step(1);
        expect_now("t3_ewy", 5, 4, 3'b100, 3'b010);

        // Test 4: late request leaves the countdown alone and is dropped.
        step(7);
        expect_now("t4_nsg", 1, 59, 3'b001, 3'b100);
        step(54);
        expect_now("t4_pre", 1, 5, 3'b001, 3'b100);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        expect_now("t4_late", 1, 4, 3'b001, 3'b100);
        step(4);
        expect_now("t4_last", 1, 0, 3'b001, 3'b100);
        step(8);
        expect_now("t4_ewg_full", 4, 59, 3'b100, 3'b001);

        // Test 5: hold freezes EW_GREEN at countdown 30 for 20 cycles.
        step(29);
        expect_now("t5_pre", 4, 30, 3'b100, 3'b001);
        bus.hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            expect_now("t5_hold", 4, 30, 3'b100, 3'b001);
        end
        bus.hold = 1'b0;
        step(30);
        expect_now("t5_last", 4, 0, 3'b100, 3'b001);
        step(1);
        expect_now("t5_ewy", 5, 4, 3'b100, 3'b010);

        // Test 6: asynchronous reset in the middle of EW_YELLOW.
        step(2);
        expect_now("t6_pre", 5, 2, 3'b100, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        expect_now("t6_rst", 0, 0, 3'b100, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        expect_now("t6_restart", 1, 59, 3'b001, 3'b100);

        // Randomized hold / request traffic, checked by the model each cycle.
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_left > 0) begin
                hold_left--;
                bus.hold = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                hold_left = $urandom_range(1, 25);
                bus.hold  = 1'b1;
            end else begin
                bus.hold = 1'b0;
            end
            bus.ped_req = ($urandom_range(0, 29) == 0);
            if (i == 2000) begin
                #2;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            step(1);
        end
        bus.hold    = 1'b0;
        bus.ped_req = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences the two signal heads of a four-way intersection: north-south (NS) and east-west (EW). It owns the phase order, the per-phase durations and the all-red clearance intervals. It also handles pedestrian shorten-green requests. Each head's red/yellow/green lamp set and a shared countdown are driven from here, so lamp drivers and the countdown display are passive consumers.

Parameters:
CNT_W, 8, width of phase counter and countdown output
GREEN_T, 60, green duration in cycles (both directions)
YELLOW_T, 5, yellow duration in cycles
ALLRED_T, 2, all-red clearance duration in cycles
MIN_GREEN, 10, green duration after a pedestrian shorten request

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
hold  in  1  freezes state and counter while high
ped_req  in  1  pedestrian shorten request, single-cycle pulse or level
ns_light  out  3  NS lamps {red,yellow,green}, one-hot
ew_light  out  3  EW lamps {red,yellow,green}, one-hot
countdown  out  CNT_W  remaining cycles in the current phase minus one
phase  out  3  current state encoding

Behaviour:
- Reset: asynchronous and active-high.
  - state=IDLE; ns_light=ew_light=3'b100 (both red); countdown=0; phase=0; ped_pending=0.
  - Reset asserted mid-phase forces the reset values immediately, with no clearance interval.
- State order: IDLE -> NS_GREEN -> NS_YELLOW -> AR1 -> EW_GREEN -> EW_YELLOW -> AR2 -> NS_GREEN, repeating.
  - Phase encodings are 0..6 in that order.
  - IDLE lasts exactly one cycle after reset release.
- Phase timing:
  - On the edge that enters a state, the counter loads duration-1.
  - The counter decrements by 1 each non-hold cycle.
  - The state advances on the edge where the counter==0 and hold==0.
  - Each phase therefore lasts exactly its duration in cycles (GREEN_T, YELLOW_T or ALLRED_T).
- Lamps:
  - Registered; they change on the same edge as the state.
  - NS_GREEN: ns=001, ew=100. NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001. EW_YELLOW: ns=100, ew=010.
  - IDLE, AR1, AR2: both 100.
  - Invariant: at least one head is red every cycle. Never both non-red.
- Pedestrian request:
  - ped_req high on any edge sets ped_pending.
  - While in a green state with ped_pending=1 and counter>MIN_GREEN-1, the next edge loads MIN_GREEN-1 and clears ped_pending.
  - In a green state with counter<=MIN_GREEN-1, ped_pending clears with no change to the counter.
  - On green entry with ped_pending=1, the counter loads MIN_GREEN-1 instead of GREEN_T-1 and ped_pending clears.
  - In yellow or all-red states, the request stays pending.
  - If ped_req and the counter==0 transition coincide, the transition wins and the request stays pending for the next green.
  - Repeated requests while pending have no further effect.
- hold:
  - State, counter and lamps are frozen.
  - ped_pending is still set by ped_req but is not acted on until hold drops.
- countdown equals the counter register, with zero latency.
- Width: durations must fit in CNT_W; MIN_GREEN<=GREEN_T. Both are checked by elaboration-time assertions. The counter never wraps below 0.

Decomposition:
- Shared package traffic_pkg contains:
  - the phase state enum (7 values, 3 bits);
  - lamp encodings LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001;
  - default duration constants.
- One sub-module, phase_timer: a loadable CNT_W down-counter with inputs load, load_val, en and output zero. The FSM, request latch and lamp decode stay in the top.

Test Plan:
1. Reset release, no requests.
   - Required: IDLE 1 cycle.
   - Then NS_GREEN 60 cycles (countdown 59..0), NS_YELLOW 5, AR1 2, EW_GREEN 60, EW_YELLOW 5, AR2 2, then back to NS_GREEN.
   - Cycle period: 134 cycles.
2. ped_req pulse at NS_GREEN countdown=40.
   - Required: next cycle countdown=9; NS_GREEN ends 10 cycles later; ped_pending=0.
3. ped_req pulse during NS_YELLOW.
   - Required: yellow is unaffected; EW_GREEN enters with countdown=9 and lasts 10 cycles.
4. ped_req at green countdown=5.
   - Required: countdown continues 4,3..0; request is cleared; the next green is full 60.
5. hold high for 20 cycles mid EW_GREEN at countdown=30.
   - Required: countdown stays 30 and lamps are frozen; after release, 31 more cycles of EW_GREEN.
6. rst asserted mid EW_YELLOW.
   - Required: both heads 100 and countdown=0 immediately.
   - Across all tests, a checker asserts that ns_light and ew_light are never both non-red.
